// File: rtl/vfu_max_buffer_if.sv
// ---------------------------------------------------------------------------
// vfu_max_buffer_if
//
// Purpose: groups the stream signals of the vector max buffer into a single
// bundle. The buffer sits in front of the lane-parallel FP16 subtractor.
// It takes in one vector as N-lane beats. It hands back each beat together
// with the vector maximum broadcast on every lane.
//
// Signals (lane i of every flat bus is [i*16 +: 16]):
//   in_data_flat  N*16  input beat
//   in_valid      1     input beat valid
//   in_last       1     final beat of the input vector
//   in_ready      1     buffer can accept a beat (fill phase)
//   out_x_flat    N*16  replayed beat, lane-aligned with the input
//   out_max_flat  N*16  vector maximum replicated on all lanes
//   out_valid     N     per-lane valid, all bits always equal
//   out_ready     N     per-lane ready, a beat moves only when all are 1
//   out_last      1     final replayed beat
//   overflow      1     sticky: a vector was truncated at DEPTH beats
//
// Modports:
//   master  the environment (producer of input beats, consumer of output)
//   slave   the buffer itself
// ---------------------------------------------------------------------------
interface vfu_max_buffer_if #(
    parameter int N = 4
);

    logic [N*16-1:0] in_data_flat;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [N*16-1:0] out_x_flat;
    logic [N*16-1:0] out_max_flat;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic            out_last;
    logic            overflow;

    modport master (
        output in_data_flat,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_x_flat,
        input  out_max_flat,
        input  out_valid,
        input  out_last,
        input  overflow
    );

    modport slave (
        input  in_data_flat,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_x_flat,
        output out_max_flat,
        output out_valid,
        output out_last,
        output overflow
    );

endinterface

// File: rtl/vfu_max_buffer.sv
// ---------------------------------------------------------------------------
// vfu_max_buffer
//
// Purpose: the upstream stage of the softmax subtract stage. The block
// works in two phases.
//   FILL    Input beats are stored in a register array. A running FP16
//           maximum is kept while they arrive.
//   REPLAY  The stored beats are played back, one per transfer. The final
//           maximum is broadcast on every lane, so the subtractor can
//           compute x - max.
// A vector longer than DEPTH beats is cut off after DEPTH beats. This sets
// the sticky overflow flag. The beats that follow form the next vector.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   vfu_max_buffer_if.slave; carries the input stream, the replay
//         stream and the overflow flag
//
// Parameters:
//   N      lanes per beat (FP16 elements per beat)
//   DEPTH  buffer depth in beats
// ---------------------------------------------------------------------------
module vfu_max_buffer #(
    parameter int N     = 4,
    parameter int DEPTH = 16
) (
    input logic             clk,
    input logic             rst,
    vfu_max_buffer_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The FP16 encoding of the quiet NaN the block reports.
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef enum logic {
        FILL,
        REPLAY
    } state_t;

    state_t          state;
    logic [N*16-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   last_idx;
    logic [15:0]     max_bits;
    logic            nan_seen;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic            overflow_r;

    logic            accept;
    logic            transfer;
    logic            first_beat;
    logic [15:0]     beat_best;
    logic            beat_has_num;
    logic            beat_has_nan;
    logic [15:0]     next_max_bits;
    logic            next_nan_seen;

    // Maps an FP16 pattern to an unsigned key. Comparing keys as integers
    // gives the floating-point order. Both zeros map to the +0 key, so they
    // tie. The tie-break then keeps the earlier element, with its sign.
    function automatic logic [15:0] fp16_key(input logic [15:0] b);
        if (b[14:0] == 15'd0) begin
            return 16'h8000;
        end else if (b[15]) begin
            return {1'b0, ~b[14:0]};
        end else begin
            return {1'b1, b[14:0]};
        end
    endfunction

    function automatic logic fp16_is_nan(input logic [15:0] b);
        return (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    endfunction

    assign accept     = (state == FILL) && bus.in_valid;
    assign transfer   = out_valid_r && (&bus.out_ready);
    assign first_beat = (wr_ptr == '0);

    // Reduce the incoming beat to its largest non-NaN lane. A lane only
    // replaces the current pick when its key is strictly greater. On a tie
    // the lower lane index stays. NaN lanes are only noted, because any
    // NaN in the vector overrides the numeric maximum anyway.
    always_comb begin
        beat_best    = bus.in_data_flat[15:0];
        beat_has_num = 1'b0;
        beat_has_nan = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (fp16_is_nan(bus.in_data_flat[i*16 +: 16])) begin
                beat_has_nan = 1'b1;
            end else if (!beat_has_num ||
                         (fp16_key(bus.in_data_flat[i*16 +: 16]) > fp16_key(beat_best))) begin
                beat_best    = bus.in_data_flat[i*16 +: 16];
                beat_has_num = 1'b1;
            end
        end
    end

    // Fold the beat result into the running maximum. The first beat of a
    // vector loads the running maximum directly. This matters because the
    // previous vector's maximum is still in the register and must not
    // participate. Later beats only win when strictly larger, so the
    // earlier beat keeps a tie.
    always_comb begin
        next_max_bits = max_bits;
        next_nan_seen = nan_seen;
        if (first_beat) begin
            next_max_bits = beat_best;
            next_nan_seen = beat_has_nan;
        end else begin
            next_nan_seen = nan_seen | beat_has_nan;
            if (beat_has_num && (fp16_key(beat_best) > fp16_key(max_bits))) begin
                next_max_bits = beat_best;
            end
        end
    end

    // Beat storage. It has no reset: the contents only matter once they
    // have been written during FILL, and out_x_flat is ignored while
    // out_valid is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.in_data_flat;
        end
    end

    // FILL/REPLAY controller with registered handshake outputs.
    // - The index of the last beat (B-1) is captured at the end of FILL.
    // - out_last is precomputed one transfer ahead. This keeps it a clean
    //   register that holds stable during stalls.
    // - A full buffer with no in_last is closed as if it were the last
    //   beat. This raises the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_idx    <= '0;
            max_bits    <= '0;
            nan_seen    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        max_bits <= next_max_bits;
                        nan_seen <= next_nan_seen;
                        if (bus.in_last || (wr_ptr == PW'(DEPTH - 1))) begin
                            state       <= REPLAY;
                            last_idx    <= wr_ptr;
                            rd_ptr      <= '0;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= (wr_ptr == '0);
                            if (!bus.in_last) begin
                                overflow_r <= 1'b1;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                REPLAY: begin
                    if (transfer) begin
                        if (out_last_r) begin
                            state       <= FILL;
                            wr_ptr      <= '0;
                            rd_ptr      <= '0;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            rd_ptr     <= rd_ptr + PW'(1);
                            out_last_r <= ((rd_ptr + PW'(1)) == last_idx);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // A NaN anywhere in the vector turns the broadcast maximum into a quiet NaN.
    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = {N{out_valid_r}};
    assign bus.out_last     = out_last_r;
    assign bus.overflow     = overflow_r;
    assign bus.out_x_flat   = mem[rd_ptr];
    assign bus.out_max_flat = {N{nan_seen ? QNAN : max_bits}};

endmodule

// File: tb/tb_vfu_max_buffer.sv
// ---------------------------------------------------------------------------
// tb_vfu_max_buffer
//
// Directed bench for vfu_max_buffer (N=4, DEPTH=16). Vectors are loaded
// into a beat table. They are streamed into the buffer and the replay is
// drained back out. Every replayed beat, maximum and last flag is checked
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_vfu_max_buffer;

    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [63:0] vec [0:19];

    vfu_max_buffer_if #(.N(N)) bus ();

    vfu_max_buffer #(
        .N    (N),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Streams vec[base .. base+nbeats-1] into the buffer, one beat per cycle.
    // The final beat carries in_last when last_flag is set.
    task automatic applyStimulus(input int base, input int nbeats, input logic last_flag);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            checkOutput("fill_in_ready", 64'(bus.in_ready), 64'd1);
            bus.in_data_flat = vec[base + i];
            bus.in_valid     = 1'b1;
            bus.in_last      = last_flag && (i == nbeats - 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Optionally stalls with a partial ready pattern, then drains the
    // replay with full ready and checks every beat.
    task automatic drainVector(input int base, input int nbeats, input logic [15:0] exp_max,
                               input logic [3:0] stall_pat, input int stall_cycles);
        int k      = 0;
        int cycles = 0;
        for (int s = 0; s < stall_cycles; s++) begin
            @(negedge clk);
            bus.out_ready = stall_pat;
            @(posedge clk);
            #1;
            checkOutput("stall_hold_x", bus.out_x_flat, vec[base]);
            checkOutput("stall_valid", 64'(bus.out_valid), 64'hF);
            checkOutput("stall_max", bus.out_max_flat, {4{exp_max}});
            checkOutput("stall_last", 64'(bus.out_last), 64'(nbeats == 1));
            checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        while (k < nbeats && cycles < 200) begin
            @(negedge clk);
            bus.out_ready = 4'hF;
            if (bus.out_valid == 4'hF) begin
                checkOutput("replay_x", bus.out_x_flat, vec[base + k]);
                checkOutput("replay_max", bus.out_max_flat, {4{exp_max}});
                checkOutput("replay_last", 64'(bus.out_last), 64'(k == nbeats - 1));
                checkOutput("replay_in_ready", 64'(bus.in_ready), 64'd0);
                k++;
            end
            @(posedge clk);
            cycles++;
        end
        checkOutput("beat_count", 64'(k), 64'(nbeats));
        #1;
        checkOutput("done_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("done_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 4'h0;
    endtask

    initial begin
        bus.in_data_flat = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.out_ready    = 4'h0;

        vec[0] = pack4(16'h3C00, 16'hC200, 16'h4000, 16'hB800);
        vec[1] = pack4(16'h3800, 16'h4200, 16'h0000, 16'hBC00);
        vec[2] = pack4(16'h8000, 16'h0000, 16'hFC00, 16'hC400);
        vec[3] = pack4(16'hFC00, 16'hC400, 16'hC200, 16'hC500);
        vec[4] = pack4(16'h7C00, 16'h7C01, 16'h3C00, 16'h0000);
        vec[5] = pack4(16'h7BFF, 16'h7C00, 16'h0000, 16'hFC00);

        // Reset state, observed while reset is still asserted.
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
        checkOutput("rst_out_max", bus.out_max_flat, 64'd0);
        checkOutput("rst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic two-beat vector; valid must appear right after the last accept.
        applyStimulus(0, 2, 1'b1);
        checkOutput("latency_valid", 64'(bus.out_valid), 64'hF);
        checkOutput("latency_max", bus.out_max_flat, {4{16'h4200}});
        drainVector(0, 2, 16'h4200, 4'h0, 0);

        // Same vector under partial-ready backpressure.
        applyStimulus(0, 2, 1'b1);
        drainVector(0, 2, 16'h4200, 4'b1011, 3);

        // Signed-zero tie keeps the earlier -0; all-negative vector; NaN; inf.
        applyStimulus(2, 1, 1'b1);
        drainVector(2, 1, 16'h8000, 4'h0, 0);
        applyStimulus(3, 1, 1'b1);
        drainVector(3, 1, 16'hC200, 4'h0, 0);
        applyStimulus(4, 1, 1'b1);
        drainVector(4, 1, 16'h7E00, 4'h0, 0);
        applyStimulus(5, 1, 1'b1);
        drainVector(5, 1, 16'h7C00, 4'h0, 0);

        // Overflow: 16 beats with no last, then a 17th beat carrying last.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 4; j++) begin
                vec[i][j*16 +: 16] = 16'(32'h1000 + i * 256 + j);
            end
        end
        vec[16] = pack4(16'hC000, 16'hBC00, 16'hC400, 16'hB800);
        checkOutput("overflow_before", 64'(bus.overflow), 64'd0);
        applyStimulus(0, 16, 1'b0);
        checkOutput("overflow_set", 64'(bus.overflow), 64'd1);
        drainVector(0, 16, 16'h1F03, 4'h0, 0);
        applyStimulus(16, 1, 1'b1);
        drainVector(16, 1, 16'hB800, 4'h0, 0);
        checkOutput("overflow_sticky", 64'(bus.overflow), 64'd1);

        // Reset in the middle of a three-beat replay.
        vec[17] = pack4(16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03);
        vec[18] = pack4(16'h4000, 16'h4001, 16'h4002, 16'h4003);
        vec[19] = pack4(16'h4400, 16'h4100, 16'h4200, 16'h4300);
        applyStimulus(17, 3, 1'b1);
        @(negedge clk);
        bus.out_ready = 4'hF;
        @(posedge clk);
        #1;
        bus.out_ready = 4'h0;
        checkOutput("mid_second_x", bus.out_x_flat, vec[18]);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rst_last", 64'(bus.out_last), 64'd0);
        checkOutput("mid_rst_overflow", 64'(bus.overflow), 64'd0);
        #1 rst = 1'b0;
        applyStimulus(18, 2, 1'b1);
        drainVector(18, 2, 16'h4400, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vfu_max_buffer.md
# vfu_max_buffer

Upstream stage of the softmax VFU subtract stage. Accepts one input vector as a stream of N-lane FP16 beats, buffers the whole vector, and reduces it to its maximum element. It then replays the buffered vector with the maximum broadcast on every lane, producing the x and max operands the lane-parallel FP16 subtractor needs to compute x − max.

## Interface

- `N`, 4: lanes per beat (FP16 elements per beat).
- `DEPTH`, 16: buffer depth in beats; maximum vector length is DEPTH·N elements.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_data_flat` input N·16: input beat; lane i is `[i*16 +: 16]`.
- `in_valid` input 1: input beat valid.
- `in_last` input 1: marks the final beat of a vector.
- `in_ready` output 1: block can accept a beat.
- `out_x_flat` output N·16: replayed beat, lane-aligned with the input.
- `out_max_flat` output N·16: vector maximum, replicated on all N lanes.
- `out_valid` output N: per-lane valid; all bits are always equal. Connects to the subtractor's per-lane `in_tvalid`.
- `out_ready` input N: per-lane ready from the subtractor; a beat transfers only when all bits are 1.
- `out_last` output 1: marks the final replayed beat.
- `overflow` output 1: sticky flag, set when a vector is truncated at DEPTH beats.

## Operation

- The FSM has two states: FILL and REPLAY. Reset enters FILL.
- **FILL state**
  - `in_ready`=1 in this state.
  - A beat is accepted when `in_valid & in_ready`. Accepted beats are written to `mem[wr_ptr]` and `wr_ptr` increments.
  - The running max updates on every accepted beat. The first beat of a vector loads the running max directly with that beat's lane maximum; no prior value participates.
  - On an accepted beat with `in_last`=1, store beat count B = `wr_ptr`+1 and go to REPLAY.
  - On an accepted beat at `wr_ptr`=DEPTH−1 with `in_last`=0, treat the beat as last, set `overflow`, and go to REPLAY. Input beats after truncation are the next vector.
- **REPLAY state**
  - `in_ready`=0 in this state.
  - `out_valid`=all ones. `out_x_flat`=`mem[rd_ptr]`. `out_max_flat`=N copies of the max register.
  - `out_last`=1 when `rd_ptr`=B−1.
  - On transfer (`&out_ready`), `rd_ptr` increments.
  - On transfer of the last beat: return to FILL and clear `wr_ptr` and `rd_ptr`. The max register holds until the next vector's first beat.
- **FP16 compare** (pure logic, no IP)
  - Sort key = `{1, bits[14:0]}` if sign=0, else `{0, ~bits[14:0]}`. Larger key is larger.
  - Magnitude 0 is mapped to the +0 key, so ±0 compare equal.
  - Infinities order naturally.
- **Ties**: the earlier element wins. Earlier beat beats later beat; lower lane index beats higher lane index within a beat. The winner's original bit pattern is kept, so −0 can be output.
- **NaN**: if any accepted element has exp=0x1F and mantissa≠0, the vector max is 0x7E00.
- `overflow` clears only on `rst`.

## Timing

- **Reset values**:
  - outputs: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_max_flat`=0, `overflow`=0;
  - internal: state=FILL, pointers=0.
- `out_x_flat` is a combinational read of the register array and is don't-care while `out_valid`=0.
- **Latency**: a last beat accepted at edge t gives `out_valid`=1 from cycle t+1 with the final max already stable.
- With no backpressure, a B-beat vector replays in cycles t+1 … t+B, and `in_ready` returns to 1 in cycle t+B+1.
- `out_x_flat`, `out_max_flat` and `out_last` hold stable while `out_valid`=1 and `&out_ready`=0.
- A partial `out_ready` (some bits 0) stalls; no lane advances independently.
- **Throughput**: one beat per cycle in each phase. Fill and replay do not overlap.
- **Single-beat vector** (`in_last` on first beat): B=1, and replay lasts one transfer.
- **`rst` mid-fill or mid-replay**: the vector is dropped immediately. Returns to FILL; no output beat completes.

## Test plan

- **Basic 2-beat vector**, N=4:
  - stimulus: {0x3C00, 0xC200, 0x4000, 0xB800}, then {0x3800, 0x4200, 0x0000, 0xBC00} with last;
  - response: 2 output beats equal to the input, `out_max_flat`=4×0x4200, `out_last` on beat 2, first `out_valid` one cycle after the last accept.
- **Backpressure**: same vector, `out_ready`=4'b1011 for 3 cycles, then 4'b1111 → output held stable, each beat transferred exactly once, `in_ready`=0 throughout replay.
- **Signed zero tie and all-negative**:
  - vector {0x8000, 0x0000, 0xFC00, 0xC400} → max 0x8000;
  - vector {0xFC00, 0xC400, 0xC200, 0xC500} → max 0xC200.
- **NaN and inf**: vector containing 0x7C00 and 0x7C01 → max 0x7E00; vector with 0x7BFF and 0x7C00 → max 0x7C00.
- **Overflow**: DEPTH=16, 17 beats with `in_last` never asserted until beat 17 → 16 beats replayed, `overflow`=1; beat 17 forms a 1-beat next vector.
- **Reset mid-replay**: `rst` pulse after 1 of 3 beats transferred → `out_valid`=0 asynchronously, `in_ready`=1; a following vector processes correctly.
